// File: rtl/sprite_scan_scheduler.sv
// Per-line sprite scheduler: scans the sprite register bank, queues up to MAX_PER_LINE
// visible sprites in slot order, then hands them one at a time to the print datapath.
module sprite_scan_scheduler #(
  parameter int NUM_SLOTS    = 8,
  parameter int MAX_PER_LINE = 4,
  parameter int SPRITE_H     = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [8:0]  pixel_y,
  output logic [2:0]  slot_addr,
  input  logic [31:0] slot_data,
  output logic [31:0] sprite_data,
  output logic        print_req,
  input  logic        print_ack,
  output logic [2:0]  visible_count,
  output logic        overflow,
  output logic        busy
);

  localparam int SCAN_W = $clog2(NUM_SLOTS + 1);
  localparam int QW     = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
  localparam logic [SCAN_W-1:0] LAST_SCAN = SCAN_W'(NUM_SLOTS);
  localparam logic [SCAN_W-1:0] LAST_ADDR = SCAN_W'(NUM_SLOTS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DISPATCH, WAIT_ACK} state_t;

  state_t             state, state_next;
  logic [8:0]         line_y;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [2:0]         k;
  logic [31:0]        queue [MAX_PER_LINE];

  logic [9:0] y_ext, line_ext, diff;
  logic       eval, visible, room, push, scan_done;
  logic [2:0] cnt_after;

  // Slot data lags its address by one clk, so scan step n evaluates slot n-1.
  assign eval      = (state == SCAN) && (scan_cnt != '0);
  assign y_ext     = {1'b0, slot_data[18:10]};
  assign line_ext  = {1'b0, line_y};
  assign diff      = line_ext - y_ext;
  assign visible   = slot_data[31] && (line_ext >= y_ext) && (diff < 10'(SPRITE_H));
  assign room      = {1'b0, visible_count} < 4'(MAX_PER_LINE);
  assign push      = eval && visible && room;
  assign scan_done = (state == SCAN) && (scan_cnt == LAST_SCAN);
  assign cnt_after = visible_count + {2'b00, push};
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (line_start) begin
      state_next = SCAN;
    end else begin
      case (state)
        SCAN:     if (scan_done) state_next = (cnt_after == 3'd0) ? IDLE : DISPATCH;
        DISPATCH: state_next = WAIT_ACK;
        WAIT_ACK: if (print_ack) state_next = ((k + 3'd1) == visible_count) ? IDLE : DISPATCH;
        default:  state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_y        <= '0;
      slot_addr     <= '0;
      scan_cnt      <= '0;
      k             <= '0;
      visible_count <= '0;
      overflow      <= 1'b0;
      sprite_data   <= '0;
      print_req     <= 1'b0;
      for (int i = 0; i < MAX_PER_LINE; i++) queue[i] <= '0;
    end else if (line_start) begin
      // A new line always wins, abandoning whatever was in flight.
      line_y        <= pixel_y;
      slot_addr     <= '0;
      scan_cnt      <= '0;
      k             <= '0;
      visible_count <= '0;
      overflow      <= 1'b0;
      print_req     <= 1'b0;
      for (int i = 0; i < MAX_PER_LINE; i++) queue[i] <= '0;
    end else begin
      case (state)
        SCAN: begin
          scan_cnt  <= scan_cnt + 1'b1;
          slot_addr <= (scan_cnt < LAST_ADDR) ? slot_addr + 3'd1 : 3'd0;
          if (push) begin
            queue[visible_count[QW-1:0]] <= slot_data;
            visible_count                <= visible_count + 3'd1;
          end
          if (eval && visible && !room) overflow <= 1'b1;
        end
        DISPATCH: begin
          sprite_data <= queue[k[QW-1:0]];
          print_req   <= 1'b1;
        end
        WAIT_ACK: begin
          if (print_ack) begin
            print_req <= 1'b0;
            k         <= k + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_scan_scheduler.sv
// Directed bench for sprite_scan_scheduler with a registered-read sprite bank model.
module tb_sprite_scan_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        line_start = 1'b0;
  logic        print_ack = 1'b0;
  logic [8:0]  pixel_y = '0;
  logic [31:0] slot_data;
  logic [2:0]  slot_addr, visible_count;
  logic [31:0] sprite_data;
  logic        print_req, overflow, busy;

  logic [31:0] bank [8];
  int errors = 0;
  int checks = 0;

  sprite_scan_scheduler #(.NUM_SLOTS(8), .MAX_PER_LINE(4), .SPRITE_H(20)) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .pixel_y(pixel_y),
    .slot_addr(slot_addr), .slot_data(slot_data), .sprite_data(sprite_data),
    .print_req(print_req), .print_ack(print_ack), .visible_count(visible_count),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) slot_data <= bank[slot_addr];

  function automatic logic [31:0] mk(input logic en, input logic [9:0] x,
                                     input logic [8:0] y, input logic [9:0] tag);
    return {en, 2'b10, x, y, tag};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic start_line(input logic [8:0] py);
    pixel_y = py;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic ack();
    print_ack = 1'b1;
    tick();
    print_ack = 1'b0;
  endtask

  task automatic clear_bank();
    for (int i = 0; i < 8; i++) bank[i] = '0;
  endtask

  initial begin
    clear_bank();
    // Reset state
    ticks(2);
    chk("rst_slot_addr", 32'(slot_addr), 32'd0);
    chk("rst_sprite_data", sprite_data, 32'd0);
    chk("rst_print_req", 32'(print_req), 32'd0);
    chk("rst_visible_count", 32'(visible_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    tick();

    // Slots 1 and 5 visible, long ack hold on the first sprite
    bank[1] = mk(1'b1, 10'd100, 9'd10, 10'h001);
    bank[5] = mk(1'b1, 10'd200, 9'd10, 10'h005);
    bank[3] = mk(1'b0, 10'd300, 9'd10, 10'h003);
    start_line(9'd15);
    chk("t1_busy_scan", 32'(busy), 32'd1);
    chk("t1_addr0", 32'(slot_addr), 32'd0);
    tick();
    chk("t1_addr1", 32'(slot_addr), 32'd1);
    ticks(8);
    chk("t1_vcount", 32'(visible_count), 32'd2);
    chk("t1_req_dispatch", 32'(print_req), 32'd0);
    chk("t1_overflow", 32'(overflow), 32'd0);
    tick();
    chk("t1_req0", 32'(print_req), 32'd1);
    chk("t1_data0", sprite_data, bank[1]);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("t1_hold_req", 32'(print_req), 32'd1);
      chk("t1_hold_data", sprite_data, bank[1]);
    end
    ack();
    chk("t1_gap", 32'(print_req), 32'd0);
    tick();
    chk("t1_req1", 32'(print_req), 32'd1);
    chk("t1_data1", sprite_data, bank[5]);
    ack();
    chk("t1_req_end", 32'(print_req), 32'd0);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_data_retained", sprite_data, bank[5]);
    chk("t1_vcount_end", 32'(visible_count), 32'd2);

    // All slots visible at the last line of their height: four dispatched, overflow
    for (int i = 0; i < 8; i++) bank[i] = mk(1'b1, 10'(i * 10), 9'd0, 10'(256 + i));
    start_line(9'd19);
    ticks(9);
    chk("t2_vcount", 32'(visible_count), 32'd4);
    chk("t2_overflow", 32'(overflow), 32'd1);
    for (int s = 0; s < 4; s++) begin
      if (s == 0) begin
        tick();
      end else begin
        print_ack = 1'b1;   // lands in DISPATCH and must be ignored
        tick();
        print_ack = 1'b0;
      end
      chk("t2_req", 32'(print_req), 32'd1);
      chk("t2_data", sprite_data, bank[s]);
      tick();
      chk("t2_req_held", 32'(print_req), 32'd1);
      ack();
      chk("t2_req_low", 32'(print_req), 32'd0);
    end
    chk("t2_busy_end", 32'(busy), 32'd0);
    chk("t2_overflow_sticky", 32'(overflow), 32'd1);
    ack();
    tick();
    chk("t2_idle_ack_busy", 32'(busy), 32'd0);
    chk("t2_idle_ack_req", 32'(print_req), 32'd0);

    // Nothing visible: diff equal to height, and sprite below the line
    clear_bank();
    bank[0] = mk(1'b1, 10'd5, 9'd10, 10'h010);
    bank[1] = mk(1'b1, 10'd6, 9'd100, 10'h011);
    bank[2] = mk(1'b0, 10'd7, 9'd0, 10'h012);
    start_line(9'd30);
    chk("t3_overflow_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t3_req_scan", 32'(print_req), 32'd0);
    end
    chk("t3_busy_9", 32'(busy), 32'd1);
    tick();
    chk("t3_busy_10", 32'(busy), 32'd0);
    chk("t3_vcount", 32'(visible_count), 32'd0);
    start_line(9'd5);
    ticks(9);
    chk("t3b_busy", 32'(busy), 32'd0);
    chk("t3b_vcount", 32'(visible_count), 32'd0);
    chk("t3b_req", 32'(print_req), 32'd0);

    // line_start (with a coincident ack) during the second sprite's wait
    clear_bank();
    bank[1] = mk(1'b1, 10'd100, 9'd10, 10'h001);
    bank[5] = mk(1'b1, 10'd200, 9'd10, 10'h005);
    start_line(9'd15);
    ticks(10);
    ack();
    tick();
    chk("t4_req_s1", 32'(print_req), 32'd1);
    chk("t4_data_s1", sprite_data, bank[5]);
    clear_bank();
    bank[3] = mk(1'b1, 10'd333, 9'd50, 10'h033);
    pixel_y = 9'd60;
    line_start = 1'b1;
    print_ack = 1'b1;
    tick();
    line_start = 1'b0;
    print_ack = 1'b0;
    chk("t4_req_drop", 32'(print_req), 32'd0);
    chk("t4_busy_rescan", 32'(busy), 32'd1);
    chk("t4_vcount_clr", 32'(visible_count), 32'd0);
    chk("t4_data_kept", sprite_data, mk(1'b1, 10'd200, 9'd10, 10'h005));
    ticks(9);
    chk("t4_vcount", 32'(visible_count), 32'd1);
    tick();
    chk("t4_req_new", 32'(print_req), 32'd1);
    chk("t4_data_new", sprite_data, bank[3]);
    ack();
    tick();
    chk("t4_busy_end", 32'(busy), 32'd0);
    chk("t4_no_resume", 32'(print_req), 32'd0);

    // Asynchronous reset during DISPATCH, then a normal line
    clear_bank();
    bank[1] = mk(1'b1, 10'd100, 9'd10, 10'h001);
    bank[5] = mk(1'b1, 10'd200, 9'd10, 10'h005);
    start_line(9'd15);
    ticks(9);
    chk("t5_pre_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("t5_rst_addr", 32'(slot_addr), 32'd0);
    chk("t5_rst_data", sprite_data, 32'd0);
    chk("t5_rst_req", 32'(print_req), 32'd0);
    chk("t5_rst_vcount", 32'(visible_count), 32'd0);
    chk("t5_rst_overflow", 32'(overflow), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    ticks(2);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("t5_quiet_req", 32'(print_req), 32'd0);
    end
    chk("t5_quiet_busy", 32'(busy), 32'd0);
    start_line(9'd15);
    ticks(9);
    chk("t5_vcount", 32'(visible_count), 32'd2);
    tick();
    chk("t5_data0", sprite_data, bank[1]);
    ack();
    tick();
    chk("t5_data1", sprite_data, bank[5]);
    ack();
    chk("t5_busy_end", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
